mvm_feeder: RTL and testbench
=============================

Name: mvm_feeder

Overview:
Upstream sequencer for the signed 8-bit MAC used for matrix-vector multiply.
- Accepts an M x N weight matrix and then an N-element vector over a valid/ready byte stream, and buffers both internally.
- Issues the M*N operand pairs (a, b, valid) to the MAC in row-major order, one pair per cycle.
- Counts the M row results the MAC returns, reports completion, and collects the MAC overflow flag for the job.

Parameters:
M, 3, matrix rows (number of MAC results per job)
N, 3, vector length; must equal the MAC vector length (3)
WIDTH, 8, operand width, two's-complement signed

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input stream element valid
s_ready  out  1  feeder can accept an element this cycle
s_data  in  WIDTH  signed element: M*N matrix elements (row-major), then N vector elements
mac_a  out  WIDTH  operand a to MAC (matrix element)
mac_b  out  WIDTH  operand b to MAC (vector element)
mac_valid  out  1  operand pair valid
mac_res_valid  in  1  MAC valid_out (one row result completed)
mac_overflow  in  1  MAC overflow pulse
busy  out  1  high from first accepted element until done
done  out  1  one-cycle pulse when all M results have returned
err_ovf  out  1  sticky: at least one overflow seen in current/last job

Behaviour:
- Reset, synchronous and active-high, clock clk. All outputs are 0 during reset and in the cycle after: s_ready, mac_a, mac_b, mac_valid, busy, done, err_ovf. All counters are 0 and the state is IDLE.
- States: IDLE, LOAD_M, LOAD_X, ISSUE, DRAIN.
- IDLE: moves to LOAD_M unconditionally on the next clock.
- s_ready is combinational: 1 exactly when the state is LOAD_M or LOAD_X. An element is accepted when s_valid && s_ready.
- LOAD_M:
  - Accepted elements fill W[r][c] row-major, with an index counter 0..M*N-1.
  - The first accept of a job sets busy=1 and clears err_ovf.
  - The accept at index M*N-1 moves to LOAD_X.
- LOAD_X:
  - Accepted elements fill X[0..N-1].
  - The accept of X[N-1] moves to ISSUE.
- ISSUE:
  - Outputs are registered. mac_valid=1 for exactly M*N consecutive cycles, starting the cycle after the last vector element is accepted.
  - In issue cycle k (k = r*N + c): mac_a=W[r][c], mac_b=X[c].
  - Issue never stalls. After the last pair, the state goes to DRAIN and mac_valid=0 on the following cycle.
  - mac_a and mac_b hold their last value when mac_valid=0.
- Result counter:
  - Counts mac_res_valid pulses in ISSUE and DRAIN only. Pulses in other states are ignored.
  - In DRAIN, when the count reaches M: done=1 for one cycle, busy=0, counters clear, and the state goes to LOAD_M.
  - s_ready rises in the same cycle done is high, so a new job can start back-to-back.
- Overflow: mac_overflow=1 in ISSUE or DRAIN sets err_ovf. err_ovf holds through done and clears on the first accept of the next job.
- Element values are stored and forwarded unchanged; the feeder does no arithmetic on data.
- Reset mid-operation (any state) aborts the job. Buffered data is discarded, err_ovf is cleared, and the block returns to IDLE.
- Reset on an already-reset block is a no-op.
- s_valid=0 in a load state leaves the load counters unchanged; gaps of any length are allowed.

Optional Feature:
MVM_KEEP_X_EN
- Macro defined:
  - Adds input port keep_x (1 bit), sampled when LOAD_M accepts its last element.
  - If keep_x=1 and a vector has been loaded since reset, LOAD_X is skipped: ISSUE follows directly and uses the previously stored X.
  - If no vector has been loaded since reset, keep_x is ignored and LOAD_X proceeds normally.
- Macro undefined: no keep_x port; every job loads its vector.

Test Plan:
- Reset, then stream W=[1,2,3,4,5,6,7,8,9] and X=[1,-1,2] with s_valid held high -> s_ready high for 12 cycles. mac_valid high for 9 consecutive cycles, with pairs (1,1),(2,-1),(3,2),(4,1),(5,-1),(6,2),(7,1),(8,-1),(9,2). With the MAC attached, results are 5,11,17, then one done pulse and busy falls.
- Same job with s_valid toggled every other cycle -> identical pair sequence. Issue starts one cycle after X[2] is accepted, and s_ready stays high during the gaps.
- W all 127, X all 127 -> the MAC signals overflow, err_ovf=1 after done. The next job's first accept clears err_ovf to 0.
- Assert reset during ISSUE at pair 4 -> next cycle mac_valid=0, busy=0 and err_ovf=0. A following full job produces the correct 9 pairs and a single done pulse.
- Two back-to-back jobs (second W = identity, X=[3,4,5]) -> the second job's first element is accepted in the done cycle. Second pairs are (1,3),(0,4),(0,5),(0,3),(1,4),(0,5),(0,3),(0,4),(1,5), and done pulses exactly twice.
- With MVM_KEEP_X_EN defined: job 1 loads X=[1,-1,2]; job 2 loads W only with keep_x=1 -> ISSUE starts the cycle after W[8] is accepted and uses X=[1,-1,2]. A keep_x=1 job issued first after reset still waits for 3 vector elements.

Source files
------------

// File: rtl/mvm_feeder.sv
// mvm_feeder: buffers an MxN weight matrix and an N-vector from a byte
// stream, then feeds the MAC one (a,b) pair per cycle in row-major order.
// Ports: clk, reset (sync, active-high); s_valid/s_ready/s_data input
// stream; mac_a/mac_b/mac_valid operand pairs; mac_res_valid/mac_overflow
// MAC feedback; busy, done (1-cycle pulse), err_ovf (sticky per job).
// Optional: MVM_KEEP_X_EN adds keep_x to reuse the last loaded vector.
module mvm_feeder #(
    parameter int M     = 3,
    parameter int N     = 3,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
`ifdef MVM_KEEP_X_EN
    input  logic                    keep_x,
`endif
    output logic signed [WIDTH-1:0] mac_a,
    output logic signed [WIDTH-1:0] mac_b,
    output logic                    mac_valid,
    input  logic                    mac_res_valid,
    input  logic                    mac_overflow,
    output logic                    busy,
    output logic                    done,
    output logic                    err_ovf
);

    localparam int MN = M * N;
    localparam int IW = $clog2(MN + 1);
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(M + 1);
    // column of the second issued pair
    localparam logic [XW-1:0] PC1 = XW'((N == 1) ? 0 : 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_M, LOAD_X, ISSUE, DRAIN
    } state_t;

    state_t state, state_d;

    logic signed [WIDTH-1:0] w_q [MN];
    logic signed [WIDTH-1:0] x_q [N];

    logic [IW-1:0] idx, idx_d, k, k_d;
    logic [XW-1:0] xi, xi_d, pc, pc_d;
    logic [RW-1:0] rc, rc_d, rc_inc;

    logic signed [WIDTH-1:0] a_d, b_d;
    logic v_d, busy_d, done_d, ovf_d;
    logic acc, keep, last_w, last_x;

    assign s_ready = (state == LOAD_M) || (state == LOAD_X);
    assign acc     = s_valid && s_ready;
    assign last_w  = (idx == IW'(MN - 1));
    assign last_x  = (xi == XW'(N - 1));
    assign rc_inc  = rc + RW'(mac_res_valid);

`ifdef MVM_KEEP_X_EN
    logic have_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            have_x <= 1'b0;
        end else if (state == LOAD_X && acc && last_x) begin
            have_x <= 1'b1;
        end
    end

    assign keep = keep_x && have_x;
`else
    assign keep = 1'b0;
`endif

    always_comb begin
        state_d = state;
        idx_d   = idx;
        xi_d    = xi;
        k_d     = k;
        pc_d    = pc;
        rc_d    = rc;
        a_d     = mac_a;
        b_d     = mac_b;
        v_d     = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        ovf_d   = err_ovf;
        unique case (state)
            IDLE: state_d = LOAD_M;
            LOAD_M: begin
                if (acc) begin
                    idx_d = idx + 1'b1;
                    if (idx == '0) begin
                        busy_d = 1'b1;
                        ovf_d  = 1'b0;
                    end
                    if (last_w) begin
                        idx_d = '0;
                        if (keep) begin
                            // vector reused: first pair goes out next cycle
                            state_d = ISSUE;
                            v_d     = 1'b1;
                            a_d     = (MN == 1) ? s_data : w_q[0];
                            b_d     = x_q[0];
                            k_d     = IW'(1);
                            pc_d    = PC1;
                        end else begin
                            state_d = LOAD_X;
                        end
                    end
                end
            end
            LOAD_X: begin
                if (acc) begin
                    xi_d = xi + 1'b1;
                    if (last_x) begin
                        xi_d    = '0;
                        state_d = ISSUE;
                        v_d     = 1'b1;
                        a_d     = w_q[0];
                        b_d     = (N == 1) ? s_data : x_q[0];
                        k_d     = IW'(1);
                        pc_d    = PC1;
                    end
                end
            end
            ISSUE: begin
                if (mac_res_valid) rc_d = rc_inc;
                if (mac_overflow) ovf_d = 1'b1;
                // k counts pairs already presented on the outputs
                if (k == IW'(MN)) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    pc_d    = '0;
                end else begin
                    v_d  = 1'b1;
                    a_d  = w_q[k];
                    b_d  = x_q[pc];
                    k_d  = k + 1'b1;
                    pc_d = (pc == XW'(N - 1)) ? '0 : pc + 1'b1;
                end
            end
            DRAIN: begin
                if (mac_res_valid) rc_d = rc_inc;
                if (mac_overflow) ovf_d = 1'b1;
                if (rc_inc == RW'(M)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rc_d    = '0;
                    state_d = LOAD_M;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            xi        <= '0;
            k         <= '0;
            pc        <= '0;
            rc        <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            xi        <= xi_d;
            k         <= k_d;
            pc        <= pc_d;
            rc        <= rc_d;
            mac_a     <= a_d;
            mac_b     <= b_d;
            mac_valid <= v_d;
            busy      <= busy_d;
            done      <= done_d;
            err_ovf   <= ovf_d;
        end
    end

    // operand buffers need no reset; stale contents are never issued
    always_ff @(posedge clk) begin
        if (state == LOAD_M && acc) w_q[idx] <= s_data;
        if (state == LOAD_X && acc) x_q[xi] <= s_data;
    end

endmodule

// File: tb/tb_mvm_feeder.sv
// tb_mvm_feeder: directed bench for mvm_feeder with a behavioural
// 3-element signed MAC (16-bit result range) attached.
module tb_mvm_feeder;

    logic clk;
    logic reset;
    logic s_valid;
    logic s_ready;
    logic signed [7:0] s_data;
`ifdef MVM_KEEP_X_EN
    logic keep_x;
`endif
    logic signed [7:0] mac_a;
    logic signed [7:0] mac_b;
    logic mac_valid;
    logic mac_res_valid;
    logic mac_overflow;
    logic busy;
    logic done;
    logic err_ovf;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int cyc = 0;

    logic inj;
    logic m_rv, m_ov;
    int m_acc, m_n;
    int res_q[$];

    mvm_feeder #(.M(3), .N(3), .WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
`ifdef MVM_KEEP_X_EN
        .keep_x(keep_x),
`endif
        .mac_a(mac_a),
        .mac_b(mac_b),
        .mac_valid(mac_valid),
        .mac_res_valid(mac_res_valid),
        .mac_overflow(mac_overflow),
        .busy(busy),
        .done(done),
        .err_ovf(err_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // MAC model: result one cycle after the third pair of a row
    always @(posedge clk) begin
        m_rv <= 1'b0;
        m_ov <= 1'b0;
        if (reset) begin
            m_acc <= 0;
            m_n   <= 0;
        end else if (mac_valid === 1'b1) begin
            if (m_n == 2) begin
                m_rv  <= 1'b1;
                m_ov  <= (m_acc + int'(mac_a) * int'(mac_b) > 32767) ||
                         (m_acc + int'(mac_a) * int'(mac_b) < -32768);
                res_q.push_back(m_acc + int'(mac_a) * int'(mac_b));
                m_acc <= 0;
                m_n   <= 0;
            end else begin
                m_acc <= m_acc + int'(mac_a) * int'(mac_b);
                m_n   <= m_n + 1;
            end
        end
    end

    assign mac_res_valid = m_rv | inj;
    assign mac_overflow  = m_ov;

    logic signed [7:0] w1[9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    logic signed [7:0] x1[3]   = '{1, -1, 2};
    logic signed [7:0] wid[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    logic signed [7:0] x345[3] = '{3, 4, 5};
    logic signed [7:0] w7f[9]  = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
    logic signed [7:0] x7f[3]  = '{127, 127, 127};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic signed [7:0] d);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", t < 40, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic load_job(input logic signed [7:0] w[9],
                            input logic signed [7:0] x[3],
                            input bit gap, input bit with_x);
        int last;
        last = with_x ? 11 : 8;
        for (int i = 0; i <= last; i++) begin
            if (i < 9) push(w[i]);
            else push(x[i-9]);
            if (i == 0) begin
                chk("busy_first", busy, 1);
                chk("ovf_clr_first", err_ovf, 0);
                chk("done_low_first", done, 0);
            end
            if (gap && i != last) begin
                chk("ready_gap", s_ready, 1);
                @(negedge clk);
            end
        end
    endtask

    task automatic check_issue(input logic signed [7:0] w[9],
                               input logic signed [7:0] x[3]);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("valid%0d", k), mac_valid, 1);
            chk($sformatf("a%0d", k), mac_a, w[k]);
            chk($sformatf("b%0d", k), mac_b, x[k % 3]);
            @(negedge clk);
        end
        chk("valid_end", mac_valid, 0);
        chk("a_hold", mac_a, w[8]);
        chk("b_hold", mac_b, x[2]);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        chk("ready_at_done", s_ready, 1);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic check_res(input int r0, input int r1, input int r2);
        int exp[3];
        exp = '{r0, r1, r2};
        chk("n_results", res_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("res%0d", i),
                (i < res_q.size()) ? res_q[i] : 32'hxxxxxxxx, exp[i]);
        end
    endtask

    initial begin
        int c0, base;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        inj     = 1'b0;
`ifdef MVM_KEEP_X_EN
        keep_x  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ready", s_ready, 0);
        chk("rst_a", mac_a, 0);
        chk("rst_b", mac_b, 0);
        chk("rst_valid", mac_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", err_ovf, 0);
        reset = 1'b0;
        chk("post_rst_ready", s_ready, 0);
        chk("post_rst_valid", mac_valid, 0);
        @(negedge clk);
        chk("load_ready", s_ready, 1);
        chk("idle_busy", busy, 0);

        // job A: held valid
        res_q.delete();
        c0 = cyc;
        load_job(w1, x1, 1'b0, 1'b1);
        chk("load_cycles", cyc - c0, 12);
        check_issue(w1, x1);
        wait_done();
        check_res(5, 11, 17);
        chk("a_ovf", err_ovf, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);

        // job B: valid toggled every other cycle
        res_q.delete();
        load_job(w1, x1, 1'b1, 1'b1);
        check_issue(w1, x1);
        wait_done();
        check_res(5, 11, 17);
        @(negedge clk);

        // job C: overflow
        res_q.delete();
        load_job(w7f, x7f, 1'b0, 1'b1);
        check_issue(w7f, x7f);
        wait_done();
        chk("ovf_at_done", err_ovf, 1);
        @(negedge clk);
        chk("ovf_hold", err_ovf, 1);
        chk("c_done_low", done, 0);

        // job D: reset at pair 4
        load_job(w7f, x7f, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d_a%0d", k), mac_a, w7f[k]);
            @(negedge clk);
        end
        chk("d_valid4", mac_valid, 1);
        chk("d_ovf4", err_ovf, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_valid", mac_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovf", err_ovf, 0);
        chk("abort_ready", s_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_reload", s_ready, 1);
        base = done_cnt;
        chk("dones_before_e", base, 3);

        // job E: spurious result pulse during load must be ignored
        res_q.delete();
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        load_job(w1, x1, 1'b0, 1'b1);
        check_issue(w1, x1);
        wait_done();
        check_res(5, 11, 17);

        // job F: back-to-back, first element accepted in done cycle
        res_q.delete();
        load_job(wid, x345, 1'b0, 1'b1);
        check_issue(wid, x345);
        wait_done();
        check_res(3, 4, 5);
        @(negedge clk);
        chk("f_done_low", done, 0);
        chk("done_ef", done_cnt - base, 2);

`ifdef MVM_KEEP_X_EN
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        keep_x = 1'b1;
        load_job(w1, x1, 1'b0, 1'b0);
        chk("kx_no_issue", mac_valid, 0);
        chk("kx_wait_x", s_ready, 1);
        for (int i = 0; i < 3; i++) push(x1[i]);
        check_issue(w1, x1);
        wait_done();
        load_job(wid, x1, 1'b0, 1'b0);
        check_issue(wid, x1);
        wait_done();
        keep_x = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
